// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared types and constants for the sliced 74181-style ALU
package ula_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SLICE_W = 4;

  // s codes, named after their logic-mode (m = 1) function
  localparam logic [3:0] S_NOT_A       = 4'h0;
  localparam logic [3:0] S_NOR         = 4'h1;
  localparam logic [3:0] S_NOTA_AND_B  = 4'h2;
  localparam logic [3:0] S_ZERO        = 4'h3;
  localparam logic [3:0] S_NAND        = 4'h4;
  localparam logic [3:0] S_NOT_B       = 4'h5;
  localparam logic [3:0] S_XOR         = 4'h6;
  localparam logic [3:0] S_A_AND_NOTB  = 4'h7;
  localparam logic [3:0] S_NOTA_OR_B   = 4'h8;
  localparam logic [3:0] S_XNOR        = 4'h9;
  localparam logic [3:0] S_B           = 4'hA;
  localparam logic [3:0] S_AND         = 4'hB;
  localparam logic [3:0] S_ONES        = 4'hC;
  localparam logic [3:0] S_A_OR_NOTB   = 4'hD;
  localparam logic [3:0] S_OR          = 4'hE;
  localparam logic [3:0] S_A           = 4'hF;

endpackage

// File: rtl/ula_nbits_seq_if.sv
// rtl/ula_nbits_seq_if.sv - request/result handshake bundle of the sequential ALU
interface ula_nbits_seq_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             c_out;
  logic             a_eq_b;

  modport master (
    output in_valid, a, b, s, m, c_in, out_ready,
    input  in_ready, out_valid, f, c_out, a_eq_b
  );

  modport slave (
    input  in_valid, a, b, s, m, c_in, out_ready,
    output in_ready, out_valid, f, c_out, a_eq_b
  );

endinterface

// File: rtl/ula_slice4.sv
// rtl/ula_slice4.sv - combinational 4-bit 74181 slice, active-high data and carry
module ula_slice4
  import ula_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out,
  output logic       all_ones
);

  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] sum;
  logic [3:0] lf;

  always_comb begin
    // Arithmetic is x + y + c_in; s[1:0] shapes x and s[3:2] shapes y
    x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};

    lf = 4'h0;
    case (s)
      S_NOT_A:      lf = ~a;
      S_NOR:        lf = ~(a | b);
      S_NOTA_AND_B: lf = ~a & b;
      S_ZERO:       lf = 4'h0;
      S_NAND:       lf = ~(a & b);
      S_NOT_B:      lf = ~b;
      S_XOR:        lf = a ^ b;
      S_A_AND_NOTB: lf = a & ~b;
      S_NOTA_OR_B:  lf = ~a | b;
      S_XNOR:       lf = ~(a ^ b);
      S_B:          lf = b;
      S_AND:        lf = a & b;
      S_ONES:       lf = 4'hF;
      S_A_OR_NOTB:  lf = a | ~b;
      S_OR:         lf = a | b;
      S_A:          lf = a;
      default:      lf = 4'h0;
    endcase

    f        = m ? lf : sum[3:0];
    c_out    = ~m & sum[4];
    all_ones = &f;
  end

endmodule

// File: rtl/ula_nbits_seq.sv
// rtl/ula_nbits_seq.sv - WIDTH-bit 74181 ALU evaluated one 4-bit slice per cycle
module ula_nbits_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ula_nbits_seq_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = $clog2(NSLICE);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   f_q;
  logic [3:0]         s_q;
  logic               m_q;
  logic               carry_q;
  logic               c_out_q;
  logic               eq_q;
  logic               out_valid_q;
  logic               idle_rdy_q;

  logic [3:0]         sl_a;
  logic [3:0]         sl_b;
  logic [3:0]         sl_f;
  logic               sl_cout;
  logic               sl_ones;
  logic               accept;
  logic               last;

  assign sl_a   = a_q[idx*SLICE_W +: SLICE_W];
  assign sl_b   = b_q[idx*SLICE_W +: SLICE_W];
  assign last   = (idx == IDX_W'(NSLICE - 1));

  // idle_rdy_q covers IDLE; DONE becomes ready as soon as the result is taken
  assign bus.in_ready = idle_rdy_q | (out_valid_q & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  ula_slice4 u_slice (
    .a        (sl_a),
    .b        (sl_b),
    .s        (s_q),
    .m        (m_q),
    .c_in     (carry_q),
    .f        (sl_f),
    .c_out    (sl_cout),
    .all_ones (sl_ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= '0;
      s_q         <= '0;
      m_q         <= 1'b0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
      idle_rdy_q  <= 1'b0;
    end else if (accept) begin
      a_q         <= bus.a;
      b_q         <= bus.b;
      s_q         <= bus.s;
      m_q         <= bus.m;
      carry_q     <= bus.c_in;
      idx         <= '0;
      eq_q        <= 1'b1;
      out_valid_q <= 1'b0;
      idle_rdy_q  <= 1'b0;
      state       <= RUN;
    end else begin
      case (state)
        IDLE: idle_rdy_q <= 1'b1;
        RUN: begin
          f_q[idx*SLICE_W +: SLICE_W] <= sl_f;
          carry_q <= sl_cout;
          eq_q    <= eq_q & sl_ones;
          if (last) begin
            idx         <= '0;
            c_out_q     <= sl_cout;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            idle_rdy_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
  assign bus.c_out     = c_out_q;
  assign bus.a_eq_b    = eq_q;

endmodule
